// File: rtl/convert_pkg.sv
// Shared definitions for the fixed-point format converter.
// Holds the mode codes describing how the output bit range sits relative
// to the input bit range, plus the elaboration-time helpers that derive
// bit weights, alignment shifts and the internal working width.
package convert_pkg;

    localparam logic [4:0] MODE_ABOVE_GAP = 5'd1;  // output wholly above input, gap between
    localparam logic [4:0] MODE_ABOVE_ADJ = 5'd2;  // output directly above input
    localparam logic [4:0] MODE_TOP_ABOVE = 5'd3;  // output top above input, bottom inside
    localparam logic [4:0] MODE_INSIDE    = 5'd4;  // output inside input, low bits dropped
    localparam logic [4:0] MODE_CONTAINS  = 5'd5;  // output contains input
    localparam logic [4:0] MODE_TOP_BELOW = 5'd6;  // output top below input top
    localparam logic [4:0] MODE_BELOW_ADJ = 5'd7;  // output directly below input
    localparam logic [4:0] MODE_BELOW_GAP = 5'd8;  // output wholly below input, gap between

    // Weight of the most significant bit of a word.
    function automatic int msb_of(input int n_bits, input int bin_pt);
        return n_bits - bin_pt - 1;
    endfunction

    // Weight of the least significant bit of a word.
    function automatic int lsb_of(input int bin_pt);
        return -bin_pt;
    endfunction

    function automatic logic [4:0] mode_of(input int n_in, input int bp_in,
                                           input int n_out, input int bp_out);
        int in_msb, in_lsb, out_msb, out_lsb;
        in_msb  = msb_of(n_in, bp_in);
        in_lsb  = lsb_of(bp_in);
        out_msb = msb_of(n_out, bp_out);
        out_lsb = lsb_of(bp_out);
        if (out_lsb > in_msb + 1)        return MODE_ABOVE_GAP;
        else if (out_lsb == in_msb + 1)  return MODE_ABOVE_ADJ;
        else if (out_lsb > in_lsb)       return (out_msb > in_msb) ? MODE_TOP_ABOVE : MODE_INSIDE;
        else if (out_msb >= in_msb)      return MODE_CONTAINS;
        else if (out_msb >= in_lsb)      return MODE_TOP_BELOW;
        else if (out_msb == in_lsb - 1)  return MODE_BELOW_ADJ;
        else                             return MODE_BELOW_GAP;
    endfunction

    // Number of low input bits discarded when moving to the output resolution.
    function automatic int shift_right(input int bp_in, input int bp_out);
        return (bp_in > bp_out) ? bp_in - bp_out : 0;
    endfunction

    // Number of zero bits appended below the input to reach the output resolution.
    function automatic int shift_left(input int bp_in, input int bp_out);
        return (bp_out > bp_in) ? bp_out - bp_in : 0;
    endfunction

    // Wide enough for the aligned input, a rounding carry and both saturation bounds.
    function automatic int work_width(input int n_in, input int n_out,
                                      input int bp_in, input int bp_out);
        return n_in + n_out + shift_left(bp_in, bp_out) + 2;
    endfunction

endpackage

// File: rtl/convert_round_sat.sv
// Combinational core of the converter: aligns the input to the output
// resolution with half-up rounding, then saturates to the output range.
// Ports:
//   din - fixed-point input sample (N_BITS_IN bits)
//   res - rounded and saturated output word (N_BITS_OUT bits)
module convert_round_sat
    import convert_pkg::*;
#(
    parameter int N_BITS_IN  = 4,
    parameter int BIN_PT_IN  = 4,
    parameter int N_BITS_OUT = 4,
    parameter int BIN_PT_OUT = 4,
    parameter int SIGNED     = 0
) (
    input  logic [N_BITS_IN-1:0]  din,
    output logic [N_BITS_OUT-1:0] res
);

    localparam int RSH  = shift_right(BIN_PT_IN, BIN_PT_OUT);
    localparam int LSH  = shift_left(BIN_PT_IN, BIN_PT_OUT);
    localparam int WIDE = work_width(N_BITS_IN, N_BITS_OUT, BIN_PT_IN, BIN_PT_OUT);
    // Position of the half-LSB rounding bit; beyond the extended word it is
    // simply the extension bit, so clamp to the top of the working word.
    localparam int RIDX = (RSH == 0) ? 0 : ((RSH - 1 < WIDE) ? RSH - 1 : WIDE - 1);

    typedef logic signed [WIDE-1:0] wide_t;

    localparam wide_t ONE   = wide_t'(1);
    localparam wide_t MAX_V = (ONE <<< (N_BITS_OUT - SIGNED)) - ONE;
    localparam wide_t MIN_V = (SIGNED != 0) ? -(ONE <<< (N_BITS_OUT - 1)) : '0;

    function automatic wide_t extend(input logic [N_BITS_IN-1:0] d);
        if (SIGNED != 0) return wide_t'(signed'(d));
        else             return wide_t'(d);
    endfunction

    // Arithmetic shift floors; adding the bit just below the new LSB turns
    // that into round-half-up for both signs.
    function automatic wide_t round_shift(input wide_t x);
        wide_t t;
        wide_t rbit;
        t    = x >>> RSH;
        rbit = '0;
        if (RSH > 0) rbit[0] = x[RIDX];
        return (t + rbit) <<< LSH;
    endfunction

    function automatic logic [N_BITS_OUT-1:0] saturate(input wide_t q);
        if (q > MAX_V)      return MAX_V[N_BITS_OUT-1:0];
        else if (q < MIN_V) return MIN_V[N_BITS_OUT-1:0];
        else                return q[N_BITS_OUT-1:0];
    endfunction

    assign res = saturate(round_shift(extend(din)));

endmodule

// File: rtl/convert.sv
// Fixed-point format converter: re-expresses din (N_BITS_IN bits,
// BIN_PT_IN fraction bits) at the output format (N_BITS_OUT bits,
// BIN_PT_OUT fraction bits) with half-up rounding and saturation.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears dout
//   din   - fixed-point input sample
//   mode  - constant code for output/input bit-range relationship
//   dout  - registered result, one cycle after din
module convert
    import convert_pkg::*;
#(
    parameter int N_BITS_IN  = 4,
    parameter int BIN_PT_IN  = 4,
    parameter int N_BITS_OUT = 4,
    parameter int BIN_PT_OUT = 4,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_BITS_IN-1:0]  din,
    output logic [4:0]            mode,
    output logic [N_BITS_OUT-1:0] dout
);

    // Depends only on parameters, so it is fixed regardless of clock or reset.
    assign mode = mode_of(N_BITS_IN, BIN_PT_IN, N_BITS_OUT, BIN_PT_OUT);

    logic [N_BITS_OUT-1:0] res_p0;

    convert_round_sat #(
        .N_BITS_IN  (N_BITS_IN),
        .BIN_PT_IN  (BIN_PT_IN),
        .N_BITS_OUT (N_BITS_OUT),
        .BIN_PT_OUT (BIN_PT_OUT),
        .SIGNED     (SIGNED)
    ) u_round_sat (
        .din (din),
        .res (res_p0)
    );

    // p0 -> p1: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= '0;
        else        dout <= res_p0;
    end

endmodule

// File: tb/tb_convert.sv
module tb_convert;
    import convert_pkg::*;

    localparam int NCFG = 9;

    typedef struct {
        int   nin;
        int   bpin;
        int   nout;
        int   bpout;
        bit   sgn;
        logic [4:0] mode;
    } cfg_t;

    typedef struct {
        int         cfg;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_bus = '0;

    logic [4:0] modes [NCFG];
    logic [7:0] outs  [NCFG];

    logic [3:0] dout_a, dout_b, dout_c, dout_f, dout_g, dout_h, dout_i;
    logic [7:0] dout_d, dout_e;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    convert #(.N_BITS_IN(4), .BIN_PT_IN(4),  .N_BITS_OUT(4), .BIN_PT_OUT(-1), .SIGNED(0))
        u_a (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[0]), .dout(dout_a));
    convert #(.N_BITS_IN(4), .BIN_PT_IN(4),  .N_BITS_OUT(4), .BIN_PT_OUT(0),  .SIGNED(0))
        u_b (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[1]), .dout(dout_b));
    convert #(.N_BITS_IN(4), .BIN_PT_IN(2),  .N_BITS_OUT(4), .BIN_PT_OUT(0),  .SIGNED(0))
        u_c (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[2]), .dout(dout_c));
    convert #(.N_BITS_IN(4), .BIN_PT_IN(2),  .N_BITS_OUT(8), .BIN_PT_OUT(4),  .SIGNED(0))
        u_d (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[3]), .dout(dout_d));
    convert #(.N_BITS_IN(4), .BIN_PT_IN(2),  .N_BITS_OUT(8), .BIN_PT_OUT(4),  .SIGNED(1))
        u_e (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[4]), .dout(dout_e));
    convert #(.N_BITS_IN(8), .BIN_PT_IN(0),  .N_BITS_OUT(4), .BIN_PT_OUT(0),  .SIGNED(0))
        u_f (.clk(clk), .rst_n(rst_n), .din(din_bus),      .mode(modes[5]), .dout(dout_f));
    convert #(.N_BITS_IN(8), .BIN_PT_IN(2),  .N_BITS_OUT(4), .BIN_PT_OUT(0),  .SIGNED(1))
        u_g (.clk(clk), .rst_n(rst_n), .din(din_bus),      .mode(modes[6]), .dout(dout_g));
    convert #(.N_BITS_IN(4), .BIN_PT_IN(-4), .N_BITS_OUT(4), .BIN_PT_OUT(4),  .SIGNED(1))
        u_h (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[7]), .dout(dout_h));
    convert #(.N_BITS_IN(4), .BIN_PT_IN(0),  .N_BITS_OUT(4), .BIN_PT_OUT(4),  .SIGNED(0))
        u_i (.clk(clk), .rst_n(rst_n), .din(din_bus[3:0]), .mode(modes[8]), .dout(dout_i));

    assign outs[0] = {4'b0, dout_a};
    assign outs[1] = {4'b0, dout_b};
    assign outs[2] = {4'b0, dout_c};
    assign outs[3] = dout_d;
    assign outs[4] = dout_e;
    assign outs[5] = {4'b0, dout_f};
    assign outs[6] = {4'b0, dout_g};
    assign outs[7] = {4'b0, dout_h};
    assign outs[8] = {4'b0, dout_i};

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{4, 4, 4, -1, 1'b0, MODE_ABOVE_GAP};
            1:       c = '{4, 4, 4, 0, 1'b0, MODE_ABOVE_ADJ};
            2:       c = '{4, 2, 4, 0, 1'b0, MODE_TOP_ABOVE};
            3:       c = '{4, 2, 8, 4, 1'b0, MODE_CONTAINS};
            4:       c = '{4, 2, 8, 4, 1'b1, MODE_CONTAINS};
            5:       c = '{8, 0, 4, 0, 1'b0, MODE_TOP_BELOW};
            6:       c = '{8, 2, 4, 0, 1'b1, MODE_INSIDE};
            7:       c = '{4, -4, 4, 4, 1'b1, MODE_BELOW_GAP};
            default: c = '{4, 0, 4, 4, 1'b0, MODE_BELOW_ADJ};
        endcase
        return c;
    endfunction

    // Real-valued model: value = din * 2^-bpin; result = floor(value*2^bpout + 0.5), clamped.
    function automatic logic [7:0] ref_conv(input int i, input logic [7:0] d);
        cfg_t   c;
        longint v, q, mx, mn;
        real    x;
        c = get_cfg(i);
        v = longint'(d) & ((longint'(1) << c.nin) - 1);
        if (c.sgn && d[c.nin-1]) v = v - (longint'(1) << c.nin);
        x = real'(v) * (2.0 ** real'(c.bpout - c.bpin));
        q = longint'($floor(x + 0.5));
        mx = c.sgn ? (longint'(1) << (c.nout - 1)) - 1 : (longint'(1) << c.nout) - 1;
        mn = c.sgn ? -(longint'(1) << (c.nout - 1)) : 0;
        if (q > mx) q = mx;
        if (q < mn) q = mn;
        return 8'(q & ((longint'(1) << c.nout) - 1));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t       vecs [10];
    logic [7:0] prev [NCFG];
    logic [7:0] cur  [NCFG];
    logic [7:0] r;

    initial begin
        // directed cases with hand-derived results
        vecs[0] = '{0, 8'h0C, 8'h00};
        vecs[1] = '{1, 8'h04, 8'h00};
        vecs[2] = '{1, 8'h08, 8'h01};
        vecs[3] = '{2, 8'h04, 8'h01};
        vecs[4] = '{2, 8'h06, 8'h02};
        vecs[5] = '{3, 8'h07, 8'h1C};
        vecs[6] = '{4, 8'h08, 8'hE0};
        vecs[7] = '{5, 8'hFF, 8'h0F};
        vecs[8] = '{6, 8'h80, 8'h08};   // -32.0 saturates to -8
        vecs[9] = '{7, 8'h01, 8'h07};   // 256 saturates to +7

        // reset state: outputs held at zero across edges while rst_n low
        din_bus = 8'h5F;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("reset_dout%0d", i), outs[i], 8'h00);
            check($sformatf("mode%0d", i), {3'b0, modes[i]}, {3'b0, get_cfg(i).mode});
        end
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven directed vectors
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 din_bus = vecs[k].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_cfg%0d", k, vecs[k].cfg), outs[vecs[k].cfg], vecs[k].exp);
        end

        // mid-stream reset: clears immediately, recovers one edge after release
        @(posedge clk);
        #1 din_bus = 8'h07;
        @(posedge clk);
        #1 check("pre_reset_d", outs[3], 8'h1C);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NCFG; i++)
            check($sformatf("async_clear%0d", i), outs[i], 8'h00);
        check("mode_in_reset", {3'b0, modes[5]}, {3'b0, MODE_TOP_BELOW});
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("after_release_d", outs[3], 8'h00);
        @(posedge clk);
        #1 check("recover_d", outs[3], 8'h1C);
        check("recover_f", outs[5], 8'h07);

        // randomized stimulus against the model, checking one-cycle latency
        for (int i = 0; i < NCFG; i++) prev[i] = ref_conv(i, din_bus);
        for (int n = 0; n < 150; n++) begin
            r = 8'($urandom);
            if (n < 4) r = (n[0]) ? 8'h80 : 8'h7F;
            din_bus = r;
            for (int i = 0; i < NCFG; i++) cur[i] = ref_conv(i, r);
            @(negedge clk);
            for (int i = 0; i < NCFG; i++)
                check($sformatf("hold%0d_cfg%0d", n, i), outs[i], prev[i]);
            @(posedge clk);
            #1;
            for (int i = 0; i < NCFG; i++) begin
                check($sformatf("rand%0d_cfg%0d din=%0h", n, i, r), outs[i], cur[i]);
                prev[i] = cur[i];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
